cordic_result_stage: RTL
========================

CORDIC_RESULT_STAGE -- requirements
Module: cordic_result_stage

Interface
REQ-001 Parameter W, default 32, meaning width of the IEEE-754 result word; bit W-1 is the sign.
REQ-002 Parameter DEPTH, default 2, meaning number of result FIFO entries; fixed at 2 for this release.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 ready_CORDIC  input  1  CORDIC sequencer result-valid level; held high until acknowledged.
REQ-006 data_cordic  input  W  unsigned-corrected CORDIC result word (X or Y register after the output mux); valid while ready_CORDIC=1.
REQ-007 operation  input  1  0=cosine, 1=sine; stable while ready_CORDIC=1.
REQ-008 shift_region_flag  input  2  angle-region code from range reduction; stable while ready_CORDIC=1.
REQ-009 ACK_FSM_CORDIC  output  1  one-cycle acknowledge to the CORDIC sequencer.
REQ-010 rd_en  input  1  consumer pop request.
REQ-011 data_out  output  W  FIFO head word; valid when out_valid=1.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 rd_err  output  1  one-cycle pulse when rd_en=1 while the FIFO is empty.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACK and DROP.
REQ-016 IDLE: if ready_CORDIC=1 and full=0, the FSM SHALL write the corrected word into the FIFO on that edge and go to ACK. Otherwise it SHALL stay in IDLE.
REQ-017 ACK: ACK_FSM_CORDIC SHALL be 1 for exactly this one cycle, and the FSM SHALL go to DROP.
REQ-018 DROP: the FSM SHALL stay until ready_CORDIC=0, then return to IDLE; no write SHALL occur in DROP.
REQ-019 Latency: ACK_FSM_CORDIC SHALL assert exactly one cycle after the capture edge. The word SHALL be visible on data_out at the capture edge when the FIFO was empty.
REQ-020 When full=1, ready_CORDIC SHALL remain unacknowledged (back-pressure). The capture SHALL occur on the first IDLE edge where full=0.
REQ-021 A write and a pop SHALL be allowed on the same edge only when the FIFO is not full; the count then stays unchanged.
REQ-022 When full=1, the write SHALL be blocked even if rd_en=1 on the same edge; the pop proceeds.
REQ-023 Sign correction SHALL be out[W-1] = data_cordic[W-1] XOR neg, with out[W-2:0] = data_cordic[W-2:0].
REQ-024 neg for cosine SHALL be: region 00 -> 0, 01 -> 1, 10 -> 0, 11 -> 1.
REQ-025 neg for sine SHALL be: region 00 -> 0, 01 -> 0, 10 -> 1, 11 -> 1.
REQ-026 If data_cordic[W-2:0]=0, out[W-1] SHALL be forced to 0 (no negative zero).
REQ-027 NaN and Inf words SHALL pass through with only the sign rule applied.
REQ-028 The FIFO SHALL be circular, with 1-bit read and write pointers wrapping modulo DEPTH and a 2-bit count of 0..2.
REQ-029 out_valid SHALL equal (count!=0), and full SHALL equal (count==DEPTH).
REQ-030 A pop on empty SHALL leave pointers and count unchanged and pulse rd_err for one cycle.
REQ-031 data_out SHALL be the registered head entry; contents of empty slots are don't-care, but data_out SHALL read 0 after reset.

Reset
REQ-032 When reset=1 at a clock edge, state SHALL be IDLE, pointers and count 0, data_out 0, and ACK_FSM_CORDIC, out_valid, full and rd_err 0.
REQ-033 Reset in ACK or DROP SHALL abort the transaction; a ready_CORDIC still high afterwards SHALL be captured again as a new result.

Verification
REQ-034 Cosine capture: op=0, region=01, data=0x3F3504F3, ready high -> FIFO empty so data_out=0xBF3504F3 at the capture edge; ACK one cycle after the capture edge; ready drops -> IDLE.
REQ-035 Sine capture with zero: op=1, region=10, data=0x00000000 -> data_out=0x00000000 (sign forced to 0).
REQ-036 Back-pressure: three results, no reads -> two ACKs, full=1, third ready held unacknowledged; one pop -> third captured next IDLE edge, ACK follows.
REQ-037 Empty read: rd_en=1 with count=0 -> rd_err pulses one cycle, count stays 0, out_valid=0.
REQ-038 Mid-transaction reset: reset asserted in ACK with ready high -> all outputs 0; after release, same word captured again, count=1.
REQ-039 Simultaneous: count=1, read and capture on same edge -> count stays 1, data_out becomes the new corrected word.

Source files
------------

// File: rtl/cordic_result_if.sv
// Result-stage bus: CORDIC producer handshake plus consumer FIFO read port.
interface cordic_result_if #(
    parameter int W = 32
);
    logic         ready_CORDIC;
    logic [W-1:0] data_cordic;
    logic         operation;
    logic [1:0]   shift_region_flag;
    logic         ACK_FSM_CORDIC;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         full;
    logic         rd_err;

    modport master (
        output ready_CORDIC,
        output data_cordic,
        output operation,
        output shift_region_flag,
        output rd_en,
        input  ACK_FSM_CORDIC,
        input  data_out,
        input  out_valid,
        input  full,
        input  rd_err
    );

    modport slave (
        input  ready_CORDIC,
        input  data_cordic,
        input  operation,
        input  shift_region_flag,
        input  rd_en,
        output ACK_FSM_CORDIC,
        output data_out,
        output out_valid,
        output full,
        output rd_err
    );
endinterface

// File: rtl/cordic_result_stage.sv
// CORDIC result stage: quadrant sign fix-up, capture handshake and a
// two-entry result FIFO with a registered head word.
module cordic_result_stage #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            reset,
    cordic_result_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_DROP
    } state_t;

    localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

    state_t       r_state;
    logic [W-1:0] r_mem [DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic [W-1:0] r_data_out;
    logic         r_ack;
    logic         r_rd_err;

    logic         w_neg;
    logic         w_sign;
    logic [W-1:0] w_corr;
    logic         w_full;
    logic         w_empty;
    logic         w_wr;
    logic         w_pop;
    logic         w_rd_ptr_n;
    logic [1:0]   w_count_n;
    logic [W-1:0] w_head_n;

    always_comb begin
        w_neg = bus.operation ? bus.shift_region_flag[1]
                              : bus.shift_region_flag[0];
        // A zero magnitude never leaves with the sign bit set.
        w_sign = (bus.data_cordic[W-1] ^ w_neg)
               & (|bus.data_cordic[W-2:0]);
        w_corr = {w_sign, bus.data_cordic[W-2:0]};
    end

    always_comb begin
        w_full     = (r_count == LP_DEPTH);
        w_empty    = (r_count == 2'd0);
        w_wr       = (r_state == S_IDLE) && bus.ready_CORDIC && !w_full;
        w_pop      = bus.rd_en && !w_empty;
        w_rd_ptr_n = r_rd_ptr ^ w_pop;
        w_count_n  = r_count + 2'(w_wr) - 2'(w_pop);
        w_head_n   = r_data_out;
        // Head slot being written this edge bypasses the array.
        if (w_wr && (w_rd_ptr_n == r_wr_ptr)) begin
            w_head_n = w_corr;
        end else if (w_count_n != 2'd0) begin
            w_head_n = r_mem[w_rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_corr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_data_out <= '0;
            r_ack      <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr ^ w_wr;
            r_rd_ptr   <= w_rd_ptr_n;
            r_count    <= w_count_n;
            r_data_out <= w_head_n;
            r_rd_err   <= bus.rd_en && w_empty;
            r_ack      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_DROP;
                end
                S_DROP: begin
                    if (!bus.ready_CORDIC) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ACK_FSM_CORDIC = r_ack;
    assign bus.data_out       = r_data_out;
    assign bus.out_valid      = (r_count != 2'd0);
    assign bus.full           = w_full;
    assign bus.rd_err         = r_rd_err;
endmodule
